// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline constants: default widths, EX/MEM field layout and its bubble clear mask.
package pipe_stage_skid_pkg;

  localparam int BITS_SIZE         = 32;
  localparam int BITS_REGS         = 5;
  localparam int BITS_DATA_DEFAULT = 64;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } exmem_ctrl_t;

  localparam int BITS_EXMEM_CTRL = $bits(exmem_ctrl_t);

  // EX/MEM layout, LSB first: ctrl | rd | store data | alu result
  localparam int EXMEM_OFF_CTRL  = 0;
  localparam int EXMEM_OFF_RD    = EXMEM_OFF_CTRL + BITS_EXMEM_CTRL;
  localparam int EXMEM_OFF_STORE = EXMEM_OFF_RD + BITS_REGS;
  localparam int EXMEM_OFF_ALU   = EXMEM_OFF_STORE + BITS_SIZE;
  localparam int BITS_EXMEM      = EXMEM_OFF_ALU + BITS_SIZE;

  localparam logic [BITS_EXMEM-1:0] EXMEM_CLEAR_MASK =
    {{(BITS_EXMEM - BITS_EXMEM_CTRL){1'b0}}, {BITS_EXMEM_CTRL{1'b1}}};

  function automatic logic [BITS_EXMEM-1:0] exmem_pack(
    input exmem_ctrl_t          ctrl,
    input logic [BITS_REGS-1:0] rd,
    input logic [BITS_SIZE-1:0] store_data,
    input logic [BITS_SIZE-1:0] alu_result
  );
    return {alu_result, store_data, rd, ctrl};
  endfunction

endpackage

// File: rtl/exmem_stage.sv
// EX/MEM wrapper: packs named fields into a skid stage so bubbles carry no memory/WB controls.
module exmem_stage
  import pipe_stage_skid_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  exmem_ctrl_t          i_ctrl,
  input  logic [BITS_REGS-1:0] i_rd,
  input  logic [BITS_SIZE-1:0] i_store_data,
  input  logic [BITS_SIZE-1:0] i_alu_result,
  output logic                 o_ready,
  output logic                 o_valid,
  output exmem_ctrl_t          o_ctrl,
  output logic [BITS_REGS-1:0] o_rd,
  output logic [BITS_SIZE-1:0] o_store_data,
  output logic [BITS_SIZE-1:0] o_alu_result,
  input  logic                 i_ready
);

  logic [BITS_EXMEM-1:0] data_in, data_out;

  assign data_in = exmem_pack(i_ctrl, i_rd, i_store_data, i_alu_result);

  pipe_stage_skid #(
    .BITS_DATA  (BITS_EXMEM),
    .CLEAR_MASK (EXMEM_CLEAR_MASK)
  ) u_stage (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_step  (i_step),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_data  (data_in),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (data_out),
    .i_ready (i_ready)
  );

  assign o_ctrl       = data_out[EXMEM_OFF_CTRL +: BITS_EXMEM_CTRL];
  assign o_rd         = data_out[EXMEM_OFF_RD +: BITS_REGS];
  assign o_store_data = data_out[EXMEM_OFF_STORE +: BITS_SIZE];
  assign o_alu_result = data_out[EXMEM_OFF_ALU +: BITS_SIZE];

endmodule

// File: rtl/pipe_stage_skid_slot.sv
// One valid+payload register; clear drops only the valid bit so the payload stays visible.
module pipe_slot #(
  parameter int BITS_DATA = 64
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clear,
  input  logic                 i_load,
  input  logic                 i_drop,
  input  logic [BITS_DATA-1:0] i_data,
  output logic                 o_valid,
  output logic [BITS_DATA-1:0] o_data
);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (i_clear) begin
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_valid <= 1'b1;
      o_data  <= i_data;
    end else if (i_drop) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a two-entry skid buffer, debug step gating and masked flush.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                   BITS_DATA  = BITS_DATA_DEFAULT,
  parameter logic [BITS_DATA-1:0] CLEAR_MASK = {BITS_DATA{1'b1}}
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_flush,
  input  logic                 i_valid,
  input  logic [BITS_DATA-1:0] i_data,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [BITS_DATA-1:0] o_data,
  input  logic                 i_ready
);

  logic                 main_valid, skid_valid;
  logic [BITS_DATA-1:0] main_data, skid_data, main_next;
  logic                 in_fire, out_fire;
  logic                 main_load, main_drop, skid_load, skid_drop;
  logic                 ready_q;

  assign in_fire   = i_valid & ready_q & i_step;
  assign out_fire  = main_valid & i_ready & i_step;
  assign main_next = skid_valid ? skid_data : i_data;

  always_comb begin
    main_load = 1'b0;
    main_drop = 1'b0;
    skid_load = 1'b0;
    skid_drop = 1'b0;
    if (i_step) begin
      if (skid_valid && out_fire) begin
        main_load = 1'b1;
        skid_drop = 1'b1;
      end else if (!skid_valid && (!main_valid || out_fire)) begin
        main_load = in_fire;
        main_drop = !in_fire;
      end else if (!skid_valid && in_fire) begin
        skid_load = 1'b1;
      end
    end
  end

  pipe_slot #(.BITS_DATA(BITS_DATA)) u_main (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_load  (main_load),
    .i_drop  (main_drop),
    .i_data  (main_next),
    .o_valid (main_valid),
    .o_data  (main_data)
  );

  pipe_slot #(.BITS_DATA(BITS_DATA)) u_skid (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_flush),
    .i_load  (skid_load),
    .i_drop  (skid_drop),
    .i_data  (i_data),
    .o_valid (skid_valid),
    .o_data  (skid_data)
  );

  // Dedicated flop tracking !skid_valid so upstream sees ready with no logic in front of it.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      ready_q <= 1'b1;
    end else if (skid_load) begin
      ready_q <= 1'b0;
    end else if (skid_drop) begin
      ready_q <= 1'b1;
    end
  end

  assign o_ready = ready_q;
  assign o_valid = main_valid;
  assign o_data  = main_valid ? main_data : (main_data & ~CLEAR_MASK);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic against a two-deep FIFO model.
module tb_pipe_stage_skid;

  localparam int          W    = 64;
  localparam logic [W-1:0] MASK = 64'hF000_0000_0000_0003;

  logic         i_clk = 1'b0;
  logic         i_reset, i_step, i_flush, i_valid, i_ready;
  logic [W-1:0] i_data;
  logic         o_ready, o_valid;
  logic [W-1:0] o_data;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] mlast;

  pipe_stage_skid #(.BITS_DATA(W), .CLEAR_MASK(MASK)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_step  (i_step),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .i_ready (i_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // The stage behaves as a FIFO of depth 2; o_data when empty shows the last head, masked.
  task automatic tick(input logic rst, input logic fl, input logic st, input logic v,
                      input logic [W-1:0] d, input logic rdy);
    int sz;
    i_reset = rst;
    i_flush = fl;
    i_step  = st;
    i_valid = v;
    i_data  = d;
    i_ready = rdy;
    sz = mq.size();
    if (rst) begin
      mq.delete();
      mlast = '0;
    end else if (fl) begin
      mq.delete();
    end else if (st) begin
      if (sz > 0 && rdy) void'(mq.pop_front());
      if (v && sz < 2) mq.push_back(d);
      if (mq.size() > 0) mlast = mq[0];
    end
    @(posedge i_clk);
    #1;
    check("o_valid", W'(o_valid), W'(mq.size() > 0));
    check("o_ready", W'(o_ready), W'(mq.size() < 2));
    check("o_data", o_data, (mq.size() > 0) ? mq[0] : (mlast & ~MASK));
  endtask

  initial begin
    i_reset = 1'b0; i_flush = 1'b0; i_step = 1'b0;
    i_valid = 1'b0; i_data = '0;    i_ready = 1'b0;
    mlast = '0;

    tick(1, 0, 1, 1, '1, 1);
    tick(1, 0, 1, 1, '1, 1);
    check("reset_data", o_data, 64'h0);
    check("reset_ready", W'(o_ready), 64'h1);

    tick(0, 0, 1, 1, 64'h1, 1);
    check("stream_1", o_data, 64'h1);
    tick(0, 0, 1, 1, 64'h2, 1);
    check("stream_2", o_data, 64'h2);
    tick(0, 0, 1, 1, 64'h3, 1);
    check("stream_3", o_data, 64'h3);
    tick(0, 0, 1, 0, 64'h0, 1);
    check("drain_masked", o_data, 64'h0);

    tick(0, 0, 1, 1, 64'hA, 0);
    tick(0, 0, 1, 1, 64'hB, 0);
    check("bp_head", o_data, 64'hA);
    check("bp_ready", W'(o_ready), 64'h0);
    tick(0, 0, 1, 0, 64'h0, 1);
    check("bp_next", o_data, 64'hB);
    check("bp_ready_back", W'(o_ready), 64'h1);
    tick(0, 0, 1, 0, 64'h0, 1);

    tick(0, 0, 1, 1, 64'hA, 0);
    tick(0, 0, 1, 1, 64'hB, 0);
    tick(0, 1, 0, 1, 64'hC, 1);
    check("flush_data", o_data, 64'h8);
    check("flush_valid", W'(o_valid), 64'h0);
    tick(0, 0, 1, 0, 64'h0, 1);
    check("flush_after", o_data, 64'h8);

    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 64'h5, 1);
    check("step_frozen", W'(o_valid), 64'h0);
    tick(0, 0, 1, 1, 64'h5, 1);
    check("step_one", o_data, 64'h5);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 64'h6, 1);
    check("step_hold", o_data, 64'h5);

    tick(0, 0, 1, 1, 64'h6, 1);
    check("simul_data", o_data, 64'h6);
    check("simul_valid", W'(o_valid), 64'h1);

    tick(0, 0, 1, 1, 64'h7, 0);
    tick(1, 1, 1, 1, '1, 1);
    check("rst_flush_data", o_data, 64'h0);

    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 9) != 0, 1'($urandom),
           {$urandom, $urandom}, $urandom_range(0, 2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline-stage register, the general successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque payload with a valid bit, ready/valid back-pressure through a two-entry skid buffer, debug single-step gating, and flush with a per-bit clear mask. It sits between any two stages of the MIPS pipeline and cuts the combinational `ready` path between them.

## Interface
- `BITS_DATA`, 64: payload width; stage fields are concatenated by the instantiating stage.
- `CLEAR_MASK`, `{BITS_DATA{1'b1}}`: a 1 marks a payload bit (control/WB/MEM bits) forced to 0 on `o_data` whenever `o_valid`=0. A 0 marks a bit passed through unmasked (e.g. branch target).
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_step`  in  1  debug-unit step enable; 0 freezes all state except reset/flush.
- `i_flush`  in  1  squash both entries (branch/jump/halt).
- `i_valid`  in  1  upstream has a payload.
- `i_data`  in  `BITS_DATA`  upstream payload.
- `o_ready`  out  1  stage can accept; driven directly from a flop.
- `o_valid`  out  1  main entry holds a payload.
- `o_data`  out  `BITS_DATA`  main payload, masked by `CLEAR_MASK` when invalid.
- `i_ready`  in  1  downstream accepts.

## Operation
- State: `main_valid`/`main_data`, `skid_valid`/`skid_data`.
- `o_ready = !skid_valid`. `in_fire = i_valid & o_ready & i_step`. `out_fire = o_valid & i_ready & i_step`.
- Priority, highest first: reset, flush, step-gated update.
- Reset: both valid bits and both payload registers go to 0. Outputs after reset: `o_valid`=0, `o_ready`=1, `o_data`=0.
- Flush (not in reset): both valid bits go to 0. Payload registers hold. Flush applies regardless of `i_step`, and an `i_valid` on the same cycle is dropped.
- When `i_step`=0 and neither reset nor flush is active: no state changes. Handshakes do not fire.
- Update when `i_step`=1:
  - If `skid_valid` and `out_fire`: main ← skid, and `skid_valid` goes to 0. `in_fire` is impossible because `o_ready`=0.
  - Else if `!skid_valid` and (`!main_valid` or `out_fire`): main ← `i_data` only on `in_fire`; `main_valid` ← `in_fire`.
  - Else if `!skid_valid` and `main_valid` and `!out_fire` and `in_fire`: skid ← `i_data`, and `skid_valid` goes to 1.
  - Otherwise: hold.
- `o_data = main_valid ? main_data : (main_data & ~CLEAR_MASK)`. A bubble therefore carries no write/read/branch controls.
- Ordering is strictly FIFO: the skid entry is always older than any later input.
- Payload is never duplicated or lost except by flush or reset.

## Timing
- Latency is 1 cycle from `in_fire` to `o_valid`, with the empty stage or the main entry draining.
- Throughput is 1 payload/cycle with `i_ready`=1.
- `o_ready` deasserts the cycle after the skid fills, and reasserts the cycle after the skid drains into main.
- No combinational path from `i_ready` to `o_ready`, or from `i_valid`/`i_data` to `o_*`. The only combinational logic on an output is the mask on `o_data`.
- Flush takes effect on the next edge: the cycle after, `o_valid`=0 and `o_ready`=1.

## Structure
- Constants go in the shared pipeline package: default widths (`BITS_SIZE`=32, `BITS_REGS`=5) and per-stage field offsets and `CLEAR_MASK` values (`EXMEM_CLEAR_MASK` etc.). Stage wrappers pack and unpack fields using these.
- One natural sub-module: `pipe_slot`, a valid+payload register with load/clear. It is instantiated twice, as main and skid.
- The stage-specific wrapper is `exmem_stage`, which maps named fields onto `pipe_stage_skid`.

## Test plan
- **Reset:** assert `i_reset` for 2 cycles with `i_valid`=1 and `i_data`=0xFF…FF. Required: `o_valid`=0, `o_ready`=1, `o_data`=0 throughout and after.
- **Streaming:** `i_step`=1, `i_ready`=1, push 0x1,0x2,0x3 on consecutive cycles. Required: `o_data` shows 0x1,0x2,0x3 one cycle later each, with `o_ready` held at 1.
- **Back-pressure:** `i_ready`=0, push 0xA then 0xB. Required: `o_valid`=1 with 0xA, and `o_ready`=0 after the second edge. Release `i_ready`: required 0xA, then 0xB, with `o_ready`=1 the cycle after 0xA leaves.
- **Flush:** stage full (main 0xA, skid 0xB) with `i_flush`=1, `i_step`=0, `i_valid`=1 and `i_data`=0xC. Required next cycle: `o_valid`=0, `o_ready`=1, and `o_data` = 0xA & ~`CLEAR_MASK`. 0xB and 0xC never appear.
- **Step gating:** `i_step`=0 for 3 cycles with `i_valid`=1, `i_ready`=1. Required: state frozen and no handshake fires. Then `i_step`=1 for one cycle: exactly one transfer.
- **Simultaneous events:** `out_fire` and `in_fire` on the same cycle with skid empty. Required: main replaced by the new payload and `o_valid` stays 1. With `i_reset` and `i_flush` both high, reset values apply.
